mips_multicycle_control: RTL and testbench

//  Multi-cycle main controller for the MIPS datapath. It replaces the purely combinational ALU decode

---
 rtl/mips_multicycle_control.sv | 163 ++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multi-cycle MIPS main controller FETCH/DECODE/EXEC/MEM/WB with mem handshake, trap and retire count
module mips_multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [5:0]          opcode_i,
  input  logic [5:0]          func_i,
  input  logic                zero_i,
  input  logic                mem_ready_i,
  output logic [1:0]          in1_mux_o,
  output logic                in2_mux_o,
  output logic [3:0]          alu_op_o,
  output logic                ir_write_o,
  output logic                pc_write_o,
  output logic [1:0]          pc_src_o,
  output logic                iord_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic                reg_write_o,
  output logic [1:0]          reg_dst_o,
  output logic [1:0]          wb_src_o,
  output logic                trap_o,
  output logic [RETIRE_W-1:0] retired_o
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  localparam logic [3:0] C_ILL = 4'd0, C_R = 4'd1, C_JR = 4'd2, C_I = 4'd3, C_BEQ = 4'd4,
                         C_BNE = 4'd5, C_LW = 4'd6, C_SW = 4'd7, C_J = 4'd8, C_JAL = 4'd9;
  state_t state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic [6:0] alu_q, alu_d, dec_alu, alu_out;
  logic [3:0] cls;
  logic retire, tmo_hit, br;
  assign tmo_inc = tmo_q + TMO_W'(1);
  assign tmo_hit = tmo_inc == TMO_W'(MEM_TIMEOUT);
  assign br = cls == C_BEQ || cls == C_BNE || cls == C_JR;
  assign {in1_mux_o, in2_mux_o, alu_op_o} = alu_out;
  assign retired_o = retired_q;
  assign retired_d = retired_q + RETIRE_W'(retire);
  // Instruction class and ALU controls {in1Mux, in2Mux, aluOp} from the held IR fields
  always_comb begin
    cls = C_ILL;
    dec_alu = '0;
    case (opcode_i)
      6'h00: begin
        cls = C_R;
        case (func_i)
          6'h00: dec_alu = 7'b00_1_0000;
          6'h02: dec_alu = 7'b00_1_0001;
          6'h03: dec_alu = 7'b00_1_0010;
          6'h04: dec_alu = 7'b00_0_0011;
          6'h06: dec_alu = 7'b00_0_0100;
          6'h07: dec_alu = 7'b00_0_0101;
          6'h08: cls = C_JR;
          6'h20, 6'h21: dec_alu = 7'b00_0_0110;
          6'h22, 6'h23: dec_alu = 7'b00_0_0111;
          6'h24: dec_alu = 7'b00_0_1000;
          6'h25: dec_alu = 7'b00_0_1001;
          6'h26: dec_alu = 7'b00_0_1010;
          6'h27: dec_alu = 7'b00_0_1011;
          6'h2a: dec_alu = 7'b00_0_1100;
          6'h2b: dec_alu = 7'b00_0_1101;
          default: cls = C_ILL;
        endcase
      end
      6'h02: cls = C_J;
      6'h03: cls = C_JAL;
      6'h04: {cls, dec_alu} = {C_BEQ, 7'b00_0_0111};
      6'h05: {cls, dec_alu} = {C_BNE, 7'b00_0_0111};
      6'h08, 6'h09: {cls, dec_alu} = {C_I, 7'b01_0_0110};
      6'h0a: {cls, dec_alu} = {C_I, 7'b01_0_1100};
      6'h0b: {cls, dec_alu} = {C_I, 7'b01_0_1101};
      6'h0c: {cls, dec_alu} = {C_I, 7'b10_0_1000};
      6'h0d: {cls, dec_alu} = {C_I, 7'b10_0_1001};
      6'h0e: {cls, dec_alu} = {C_I, 7'b10_0_1010};
      6'h0f: {cls, dec_alu} = {C_I, 7'b10_0_1110};
      6'h23: {cls, dec_alu} = {C_LW, 7'b01_0_0110};
      6'h2b: {cls, dec_alu} = {C_SW, 7'b01_0_0110};
      default: cls = C_ILL;
    endcase
  end
  // Next state, timeout, retire and per-state strobes; reset forces every strobe low
  always_comb begin
    state_d = state_q;
    tmo_d = '0;
    alu_d = alu_q;
    retire = 1'b0;
    alu_out = '0;
    ir_write_o = 1'b0;
    pc_write_o = 1'b0;
    pc_src_o = 2'b00;
    iord_o = 1'b0;
    mem_req_o = 1'b0;
    mem_we_o = 1'b0;
    reg_write_o = 1'b0;
    reg_dst_o = 2'b00;
    wb_src_o = 2'b00;
    trap_o = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req_o = 1'b1;
        ir_write_o = mem_ready_i;
        pc_write_o = mem_ready_i;
        tmo_d = mem_ready_i ? '0 : tmo_inc;
        state_d = mem_ready_i ? DECODE : tmo_hit ? TRAP : FETCH;
      end
      DECODE: begin
        alu_d = '0;
        pc_write_o = cls == C_J;
        pc_src_o = cls == C_J ? 2'b10 : 2'b00;
        retire = cls == C_J;
        state_d = cls == C_J ? FETCH : cls == C_JAL ? WB : cls == C_ILL ? TRAP : EXEC;
      end
      EXEC: begin
        alu_out = dec_alu;
        alu_d = dec_alu;
        pc_write_o = cls == C_BEQ ? zero_i : cls == C_BNE ? ~zero_i : cls == C_JR;
        pc_src_o = cls == C_JR ? 2'b11 : br ? 2'b01 : 2'b00;
        retire = br;
        state_d = br ? FETCH : (cls == C_LW || cls == C_SW) ? MEM : WB;
      end
      MEM: begin
        alu_out = alu_q;
        mem_req_o = 1'b1;
        iord_o = 1'b1;
        mem_we_o = cls == C_SW;
        tmo_d = mem_ready_i ? '0 : tmo_inc;
        retire = mem_ready_i && cls == C_SW;
        state_d = mem_ready_i ? (cls == C_SW ? FETCH : WB) : tmo_hit ? TRAP : MEM;
      end
      WB: begin
        alu_out = alu_q;
        reg_write_o = 1'b1;
        reg_dst_o = cls == C_JAL ? 2'b10 : cls == C_R ? 2'b01 : 2'b00;
        wb_src_o = cls == C_JAL ? 2'b10 : cls == C_LW ? 2'b01 : 2'b00;
        retire = 1'b1;
        state_d = FETCH;
      end
      TRAP: trap_o = 1'b1;
      default: state_d = FETCH;
    endcase
    if (reset_i)
      {alu_out, ir_write_o, pc_write_o, pc_src_o, iord_o, mem_req_o, mem_we_o,
       reg_write_o, reg_dst_o, wb_src_o, trap_o} = '0;
  end
  // State, timeout counter, latched ALU controls and retired count
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= FETCH;
      tmo_q <= '0;
      alu_q <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_q <= tmo_d;
      alu_q <= alu_d;
      retired_q <= retired_d;
    end
  end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: randomized instruction sequences checked cycle by cycle against a table-driven model
module tb_mips_multicycle_control;
  localparam int TMO = 16;
  localparam int R = 0, JR = 1, I = 2, BEQ = 3, BNE = 4, LW = 5, SW = 6, J = 7, JAL = 8, ILL = 9;
  localparam int PF = 0, PD = 1, PE = 2, PM = 3, PW = 4, PT = 5;
  typedef struct {
    string name;
    logic [5:0] op;
    logic [5:0] fn;
    int cls;
    logic [6:0] alu;
  } ins_t;
  logic clk = 0, reset_i = 1, zero_i = 0, mem_ready_i = 0;
  logic [5:0] opcode_i = 0, func_i = 0;
  logic [1:0] in1_mux_o, pc_src_o, reg_dst_o, wb_src_o;
  logic [3:0] alu_op_o;
  logic in2_mux_o, ir_write_o, pc_write_o, iord_o, mem_req_o, mem_we_o, reg_write_o, trap_o;
  logic [31:0] retired_o;
  logic [19:0] obs;
  ins_t tab[$];
  ins_t cur;
  bit cur_zero;
  int errs = 0, checks = 0, exp_ret = 0, ncyc = 0;
  int lat[10] = '{4, 3, 4, 3, 3, 5, 4, 2, 3, 0};
  mips_multicycle_control #(.MEM_TIMEOUT(TMO), .TMO_W(5), .RETIRE_W(32)) dut (
    .clk_i(clk), .reset_i(reset_i), .opcode_i(opcode_i), .func_i(func_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .in1_mux_o(in1_mux_o), .in2_mux_o(in2_mux_o), .alu_op_o(alu_op_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .pc_src_o(pc_src_o), .iord_o(iord_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
    .wb_src_o(wb_src_o), .trap_o(trap_o), .retired_o(retired_o)
  );
  assign obs = {in1_mux_o, in2_mux_o, alu_op_o, ir_write_o, pc_write_o, pc_src_o, iord_o,
                mem_req_o, mem_we_o, reg_write_o, reg_dst_o, wb_src_o, trap_o};
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void add(string n, logic [5:0] op, logic [5:0] fn, int cls, logic [6:0] alu);
    ins_t e;
    e.name = n; e.op = op; e.fn = fn; e.cls = cls; e.alu = alu;
    tab.push_back(e);
  endfunction
  function automatic int find(string n);
    foreach (tab[k]) if (tab[k].name == n) return k;
    return 0;
  endfunction
  function automatic logic [19:0] expect_vec(int ph, bit rdy);
    logic [6:0] alu = 0;
    logic irw = 0, pcw = 0, iord = 0, mreq = 0, mwe = 0, rw = 0, tr = 0;
    logic [1:0] src = 0, dst = 0, wbs = 0;
    case (ph)
      PF: begin mreq = 1; irw = rdy; pcw = rdy; end
      PD: if (cur.cls == J) begin pcw = 1; src = 2; end
      PE: begin
        alu = cur.alu;
        if (cur.cls == BEQ) begin pcw = cur_zero; src = 1; end
        else if (cur.cls == BNE) begin pcw = !cur_zero; src = 1; end
        else if (cur.cls == JR) begin pcw = 1; src = 3; end
      end
      PM: begin alu = cur.alu; mreq = 1; iord = 1; mwe = cur.cls == SW; end
      PW: begin
        alu = cur.cls == JAL ? 7'd0 : cur.alu;
        rw = 1;
        dst = cur.cls == JAL ? 2 : cur.cls == R ? 1 : 0;
        wbs = cur.cls == JAL ? 2 : cur.cls == LW ? 1 : 0;
      end
      PT: tr = 1;
      default: ;
    endcase
    return {alu, irw, pcw, src, iord, mreq, mwe, rw, dst, wbs, tr};
  endfunction
  task automatic cyc(int ph, bit rdy);
    @(negedge clk);
    reset_i = 0;
    mem_ready_i = rdy;
    zero_i = ph == PE ? cur_zero : 1'($urandom);
    opcode_i = ph == PF ? 6'($urandom) : cur.op;
    func_i = ph == PF ? 6'($urandom) : cur.fn;
    #1;
    check($sformatf("%s/ph%0d", cur.name, ph), {12'd0, obs}, {12'd0, expect_vec(ph, rdy)});
    check($sformatf("%s/retired", cur.name), retired_o, exp_ret);
    ncyc++;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_i = 1;
    mem_ready_i = 1'($urandom);
    #1;
    check("reset_outs", {12'd0, obs}, 0);
    exp_ret = 0;
  endtask
  task automatic run(int idx, bit z, int fs, int ms);
    bit tr = 0;
    cur = tab[idx];
    if (cur.op != 0) cur.fn = 6'($urandom);
    cur_zero = z;
    ncyc = 0;
    for (int s = 0; s <= fs && !tr; s++) begin
      cyc(PF, s == fs);
      if (s != fs && s + 1 == TMO) tr = 1;
    end
    if (!tr) begin
      cyc(PD, 1'($urandom));
      case (cur.cls)
        ILL: tr = 1;
        R, I: begin cyc(PE, 1'($urandom)); cyc(PW, 1'($urandom)); end
        BEQ, BNE, JR: cyc(PE, 1'($urandom));
        JAL: cyc(PW, 1'($urandom));
        LW, SW: begin
          cyc(PE, 1'($urandom));
          for (int s = 0; s <= ms && !tr; s++) begin
            cyc(PM, s == ms);
            if (s != ms && s + 1 == TMO) tr = 1;
          end
          if (!tr && cur.cls == LW) cyc(PW, 1'($urandom));
        end
        default: ;
      endcase
    end
    if (tr) begin
      repeat (3) cyc(PT, 1'($urandom));
      do_reset();
    end else begin
      exp_ret++;
      check($sformatf("%s/latency", cur.name), ncyc,
            lat[cur.cls] + fs + ((cur.cls == LW || cur.cls == SW) ? ms : 0));
    end
  endtask
  initial begin
    add("sll", 6'h00, 6'h00, R, 7'b00_1_0000); add("srl", 6'h00, 6'h02, R, 7'b00_1_0001);
    add("sra", 6'h00, 6'h03, R, 7'b00_1_0010); add("sllv", 6'h00, 6'h04, R, 7'b00_0_0011);
    add("srlv", 6'h00, 6'h06, R, 7'b00_0_0100); add("srav", 6'h00, 6'h07, R, 7'b00_0_0101);
    add("jr", 6'h00, 6'h08, JR, 7'b0); add("add", 6'h00, 6'h20, R, 7'b00_0_0110);
    add("addu", 6'h00, 6'h21, R, 7'b00_0_0110); add("sub", 6'h00, 6'h22, R, 7'b00_0_0111);
    add("subu", 6'h00, 6'h23, R, 7'b00_0_0111); add("and", 6'h00, 6'h24, R, 7'b00_0_1000);
    add("or", 6'h00, 6'h25, R, 7'b00_0_1001); add("xor", 6'h00, 6'h26, R, 7'b00_0_1010);
    add("nor", 6'h00, 6'h27, R, 7'b00_0_1011); add("slt", 6'h00, 6'h2a, R, 7'b00_0_1100);
    add("sltu", 6'h00, 6'h2b, R, 7'b00_0_1101); add("j", 6'h02, 6'h00, J, 7'b0);
    add("jal", 6'h03, 6'h00, JAL, 7'b0); add("beq", 6'h04, 6'h00, BEQ, 7'b00_0_0111);
    add("bne", 6'h05, 6'h00, BNE, 7'b00_0_0111); add("addi", 6'h08, 6'h00, I, 7'b01_0_0110);
    add("addiu", 6'h09, 6'h00, I, 7'b01_0_0110); add("slti", 6'h0a, 6'h00, I, 7'b01_0_1100);
    add("sltiu", 6'h0b, 6'h00, I, 7'b01_0_1101); add("andi", 6'h0c, 6'h00, I, 7'b10_0_1000);
    add("ori", 6'h0d, 6'h00, I, 7'b10_0_1001); add("xori", 6'h0e, 6'h00, I, 7'b10_0_1010);
    add("lui", 6'h0f, 6'h00, I, 7'b10_0_1110); add("lw", 6'h23, 6'h00, LW, 7'b01_0_0110);
    add("sw", 6'h2b, 6'h00, SW, 7'b01_0_0110); add("ill_op", 6'h3f, 6'h00, ILL, 7'b0);
    add("ill_fn", 6'h00, 6'h01, ILL, 7'b0);
    cur = tab[0];
    repeat (2) do_reset();
    run(find("add"), 0, 0, 0);
    run(find("lw"), 0, 0, 3);
    run(find("beq"), 1, 0, 0);
    run(find("beq"), 0, 0, 0);
    run(find("bne"), 1, 0, 0);
    run(find("jal"), 0, 0, 0);
    run(find("j"), 0, 0, 0);
    run(find("jr"), 0, 1, 0);
    run(find("sw"), 0, 2, 1);
    run(find("ill_op"), 0, 0, 0);
    run(find("add"), 0, 15, 0);
    run(find("add"), 0, 16, 0);
    run(find("lw"), 0, 0, 15);
    run(find("sw"), 0, 0, 16);
    cur = tab[find("sw")];
    cur_zero = 0;
    cyc(PF, 1); cyc(PD, 0); cyc(PE, 0); cyc(PM, 0);
    do_reset();
    run(find("add"), 0, 0, 0);
    repeat (400) begin
      int fs, ms;
      fs = $urandom_range(0, 24) == 0 ? $urandom_range(14, 16) : $urandom_range(0, 2);
      ms = $urandom_range(0, 24) == 0 ? $urandom_range(14, 16) : $urandom_range(0, 2);
      run($urandom_range(0, tab.size() - 1), 1'($urandom), fs, ms);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
